tone_arbiter: RTL and testbench
===============================

// Module: tone_arbiter
// PURPOSE
//  Shares one square-wave tone generator between N_REQ melody requesters (note sequencers).
//  - Arbitrates requests round-robin and latches the winner's note (half-period, duration).
//  - Plays the note, inserts a silent gap, then signals completion.
//  - Sits between the melody ROM/sequencer blocks and the board speaker pin.
// PARAMETERS
//  N_REQ     4          number of requesters (2..8)
//  TICK_DIV  6_250_000  iCLK cycles per duration tick
//  HP_W      21         width of half-period field (iCLK cycles per half wave)
//  DUR_W     9          width of duration field (ticks)
//  GAP_TICKS 1          silent ticks after each note
// PORTS
//  iCLK          in   1            system clock
//  iRST          in   1            reset: synchronous, active-high
//  iREQ          in   N_REQ        per-requester note request, level; held until oGNT
//  iHALF_PERIOD  in   N_REQ*HP_W   packed half-periods, requester k at [k*HP_W +: HP_W]; 0 = rest
//  iDURATION     in   N_REQ*DUR_W  packed durations in ticks, requester k at [k*DUR_W +: DUR_W]
//  oGNT          out  N_REQ        one-hot, 1-cycle pulse: note accepted
//  oDONE         out  N_REQ        one-hot, 1-cycle pulse: note + gap finished
//  oBUSY         out  1            high in PLAY or GAP
//  oACTIVE_ID    out  $clog2(N_REQ) index of requester being played
//  oSOUND        out  1            square-wave speaker output
// BEHAVIOUR
//  - Reset (iRST=1 at posedge): state=IDLE; oSOUND=0, oGNT=0, oDONE=0, oBUSY=0, oACTIVE_ID=0.
//    RR pointer makes requester 0 highest priority. Reset mid-note aborts the note, no oDONE.
//  - FSM IDLE -> PLAY -> GAP -> IDLE.
//  - IDLE, any iREQ high:
//    - winner = first set bit searching from (last_granted+1) mod N_REQ.
//    - Same cycle: latch winner's half-period and duration, oGNT[winner]=1, oACTIVE_ID=winner.
//    - Next cycle: PLAY; cycle/tick/tone counters cleared. Grant latency 1 cycle from request in IDLE.
//  - Request handshake: data sampled only in the grant cycle. Requester drops or renews iREQ after oGNT.
//    iREQ still high in the cycle after oGNT is ignored; FSM is in PLAY.
//  - PLAY:
//    - Tick counter counts iCLK to TICK_DIV-1, then wraps and pulses tick.
//    - Tone counter counts to hp-1, then wraps and toggles oSOUND; first toggle occurs hp cycles after PLAY entry.
//    - hp==0: oSOUND held 0 (rest).
//    - Note ends after dur ticks (dur==0 treated as 1): exactly dur*TICK_DIV cycles in PLAY. Then GAP, oSOUND forced 0.
//  - GAP: oSOUND=0 for GAP_TICKS*TICK_DIV cycles.
//    Last cycle: oDONE[oACTIVE_ID]=1, state->IDLE. Next arbitration the following cycle.
//  - oBUSY=1 exactly in PLAY and GAP. oACTIVE_ID holds until the next grant.
//  - Simultaneous requests are served in RR order; no requester waits more than N_REQ-1 notes.
//  - Counters sized from params, no overflow: tone HP_W bits, duration DUR_W bits, tick $clog2(TICK_DIV).
// CONFIGURATION
//  - TONE_ARB_PREEMPT_EN defined: requester 0 preempts.
//    - iREQ[0]=1 in PLAY or GAP while oACTIVE_ID!=0: current note aborted, oSOUND=0, no oDONE for it.
//    - Next cycle: IDLE with forced grant to requester 0. RR pointer unaffected by forced grants.
//  - Not defined: requester 0 arbitrates like the others; no abort path is synthesised.
// TESTING (bench params TICK_DIV=4, GAP_TICKS=1, N_REQ=4)
//  1. Reset then iREQ=4'b0001, hp0=3, dur0=2:
//     oGNT=0001 in 1 cycle; oSOUND toggles every 3 cycles for 8 cycles; 4 silent cycles; oDONE=0001.
//  2. iREQ=4'b1111 held, all dur=1:
//     grant order 0,1,2,3,0; each grant 1 cycle after the previous oDONE.
//  3. hp=0, dur=3:
//     oSOUND stays 0 for 12+4 cycles; oBUSY high for 16 cycles; oDONE pulses once.
//  4. dur=0, hp=1:
//     treated as dur=1; oSOUND toggles every cycle for 4 cycles; oDONE after 8 cycles in PLAY+GAP.
//  5. iRST asserted mid-PLAY:
//     next cycle oSOUND=0, oBUSY=0, no oDONE; a later iREQ=1010 grants requester 1 first.
//  6. TONE_ARB_PREEMPT_EN, requester 2 playing dur=5, iREQ[0] at tick 2:
//     note aborted, oGNT=0001 next cycle, no oDONE[2].
//     Without the macro: requester 0 is granted only after oDONE[2].

Source files
------------

// File: rtl/tone_arbiter.sv
// tone_arbiter: round-robin share of one square-wave tone generator among N_REQ note requesters
// Ports: iCLK/iRST (sync active-high), iREQ level requests, iHALF_PERIOD/iDURATION packed note data,
// oGNT/oDONE one-hot pulses, oBUSY in PLAY/GAP, oACTIVE_ID current requester, oSOUND speaker.
// Optional TONE_ARB_PREEMPT_EN: requester 0 aborts any other note and is granted next.
module tone_arbiter #(
  parameter int N_REQ     = 4,
  parameter int TICK_DIV  = 6_250_000,
  parameter int HP_W      = 21,
  parameter int DUR_W     = 9,
  parameter int GAP_TICKS = 1
) (
  input  logic                       iCLK,
  input  logic                       iRST,
  input  logic [N_REQ-1:0]           iREQ,
  input  logic [N_REQ*HP_W-1:0]      iHALF_PERIOD,
  input  logic [N_REQ*DUR_W-1:0]     iDURATION,
  output logic [N_REQ-1:0]           oGNT,
  output logic [N_REQ-1:0]           oDONE,
  output logic                       oBUSY,
  output logic [$clog2(N_REQ)-1:0]   oACTIVE_ID,
  output logic                       oSOUND
);
  localparam int IW = $clog2(N_REQ);
  localparam int TW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam int GW = GAP_TICKS > 1 ? $clog2(GAP_TICKS) : 1;
  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;
  state_t            state_q;
  logic [IW-1:0]     last_q, id_q, win, idx, sel;
  logic [HP_W-1:0]   hp_q, tcnt_q;
  logic [DUR_W-1:0]  dur_q, dcnt_q, dlast;
  logic [TW-1:0]     tick_q;
  logic [GW-1:0]     gcnt_q;
  logic [N_REQ-1:0]  gnt_q, done_q;
  logic              snd_q, tick, frc, go;
`ifdef TONE_ARB_PREEMPT_EN
  logic              force_q;
  assign frc = force_q;
`else
  assign frc = 1'b0;
`endif
  // Iterate from farthest to nearest so the nearest requester after last_q wins.
  always_comb begin
    win = '0;
    idx = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      idx = IW'((int'(last_q) + i) % N_REQ);
      if (iREQ[idx]) win = idx;
    end
  end
  assign sel   = frc ? '0 : win;
  assign go    = frc | (|iREQ);
  assign tick  = tick_q == TW'(TICK_DIV - 1);
  assign dlast = (dur_q == '0) ? '0 : dur_q - 1'b1;
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q <= IDLE;
      last_q  <= IW'(N_REQ - 1);
      id_q    <= '0;
      hp_q    <= '0;
      dur_q   <= '0;
      tcnt_q  <= '0;
      dcnt_q  <= '0;
      tick_q  <= '0;
      gcnt_q  <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      snd_q   <= 1'b0;
`ifdef TONE_ARB_PREEMPT_EN
      force_q <= 1'b0;
`endif
    end else begin
      gnt_q  <= '0;
      done_q <= '0;
      case (state_q)
        IDLE: if (go) begin
          hp_q    <= iHALF_PERIOD[sel*HP_W +: HP_W];
          dur_q   <= iDURATION[sel*DUR_W +: DUR_W];
          gnt_q   <= N_REQ'(1) << sel;
          id_q    <= sel;
          if (!frc) last_q <= sel;
          tcnt_q  <= '0;
          dcnt_q  <= '0;
          tick_q  <= '0;
          snd_q   <= 1'b0;
          state_q <= PLAY;
`ifdef TONE_ARB_PREEMPT_EN
          force_q <= 1'b0;
`endif
        end
        PLAY: begin
          tick_q <= tick ? '0 : tick_q + 1'b1;
          if (hp_q != '0) begin
            tcnt_q <= (tcnt_q == hp_q - 1'b1) ? '0 : tcnt_q + 1'b1;
            if (tcnt_q == hp_q - 1'b1) snd_q <= ~snd_q;
          end
          if (tick) begin
            dcnt_q <= dcnt_q + 1'b1;
            if (dcnt_q == dlast) begin
              state_q <= GAP;
              gcnt_q  <= '0;
              snd_q   <= 1'b0;
            end
          end
        end
        GAP: begin
          tick_q <= tick ? '0 : tick_q + 1'b1;
          snd_q  <= 1'b0;
          if (tick) begin
            gcnt_q <= gcnt_q + 1'b1;
            if (gcnt_q == GW'(GAP_TICKS - 1)) begin
              state_q <= IDLE;
              done_q  <= N_REQ'(1) << id_q;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
`ifdef TONE_ARB_PREEMPT_EN
      // Abort wins over a coincident end of gap: the aborted note never reports done.
      if (state_q != IDLE && iREQ[0] && id_q != '0) begin
        state_q <= IDLE;
        snd_q   <= 1'b0;
        done_q  <= '0;
        force_q <= 1'b1;
      end
`endif
    end
  end
  assign oGNT       = gnt_q;
  assign oDONE      = done_q;
  assign oBUSY      = state_q != IDLE;
  assign oACTIVE_ID = id_q;
  assign oSOUND     = snd_q;
endmodule

// File: tb/tb_tone_arbiter.sv
// tb_tone_arbiter: directed self-checking bench for tone_arbiter (TICK_DIV=4, GAP_TICKS=1, N_REQ=4)
module tb_tone_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [83:0] hp = '0;
  logic [35:0] dur = '0;
  logic [3:0]  gnt, done;
  logic        busy, snd;
  logic [1:0]  aid;
  int checks = 0;
  int errors = 0;
  tone_arbiter #(.N_REQ(4), .TICK_DIV(4), .HP_W(21), .DUR_W(9), .GAP_TICKS(1)) dut (
    .iCLK(clk), .iRST(rst), .iREQ(req), .iHALF_PERIOD(hp), .iDURATION(dur),
    .oGNT(gnt), .oDONE(done), .oBUSY(busy), .oACTIVE_ID(aid), .oSOUND(snd)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic set_note(input int k, input int h, input int d);
    hp[k*21 +: 21] = 21'(h);
    dur[k*9 +: 9]  = 9'(d);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    step();
    step();
    rst = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    req = '0;
    step();
    step();
    if (gnt !== 4'b0) begin errors++; $display("FAIL reset_gnt got %b want 0000", gnt); end
    checks++;
    if (done !== 4'b0) begin errors++; $display("FAIL reset_done got %b want 0000", done); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++;
    if (aid !== 2'd0) begin errors++; $display("FAIL reset_aid got %0d want 0", aid); end
    checks++;
    if (snd !== 1'b0) begin errors++; $display("FAIL reset_sound got %b want 0", snd); end
    checks++;
    rst = 1'b0;
  endtask
  task automatic test_basic_note();
    logic exp;
    do_reset();
    set_note(0, 3, 2);
    req = 4'b0001;
    step();
    if (gnt !== 4'b0001) begin errors++; $display("FAIL note_gnt got %b want 0001", gnt); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL note_busy got %b want 1", busy); end
    checks++;
    req = '0;
    for (int k = 0; k < 8; k++) begin
      exp = ((k / 3) % 2) == 1;
      if (snd !== exp) begin errors++; $display("FAIL note_sound c%0d got %b want %b", k, snd, exp); end
      checks++;
      step();
    end
    for (int g = 0; g < 4; g++) begin
      if (snd !== 1'b0 || busy !== 1'b1 || done !== 4'b0) begin
        errors++; $display("FAIL note_gap c%0d got snd=%b busy=%b done=%b want 0 1 0000", g, snd, busy, done);
      end
      checks++;
      step();
    end
    if (done !== 4'b0001) begin errors++; $display("FAIL note_done got %b want 0001", done); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL note_idle_busy got %b want 0", busy); end
    checks++;
    step();
    if (done !== 4'b0) begin errors++; $display("FAIL note_done_pulse got %b want 0000", done); end
    checks++;
  endtask
  task automatic test_round_robin();
    logic [3:0] exp;
    do_reset();
    for (int k = 0; k < 4; k++) set_note(k, 1, 1);
    req = 4'b1111;
    step();
    for (int n = 0; n < 5; n++) begin
      exp = 4'b0001 << (n % 4);
      if (gnt !== exp) begin errors++; $display("FAIL rr_gnt n%0d got %b want %b", n, gnt, exp); end
      checks++;
      if (aid !== 2'(n % 4)) begin errors++; $display("FAIL rr_aid n%0d got %0d want %0d", n, aid, n % 4); end
      checks++;
      if (n < 4) begin
        repeat (8) step();
        if (done !== exp) begin errors++; $display("FAIL rr_done n%0d got %b want %b", n, done, exp); end
        checks++;
        step();
      end
    end
    req = '0;
    repeat (9) step();
  endtask
  task automatic test_rest();
    do_reset();
    set_note(2, 0, 3);
    req = 4'b0100;
    step();
    if (gnt !== 4'b0100) begin errors++; $display("FAIL rest_gnt got %b want 0100", gnt); end
    checks++;
    req = '0;
    for (int c = 0; c < 16; c++) begin
      if (busy !== 1'b1 || snd !== 1'b0 || done !== 4'b0) begin
        errors++; $display("FAIL rest_play c%0d got busy=%b snd=%b done=%b want 1 0 0000", c, busy, snd, done);
      end
      checks++;
      step();
    end
    if (done !== 4'b0100) begin errors++; $display("FAIL rest_done got %b want 0100", done); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rest_busy_end got %b want 0", busy); end
    checks++;
    step();
    if (aid !== 2'd2) begin errors++; $display("FAIL rest_aid_hold got %0d want 2", aid); end
    checks++;
  endtask
  task automatic test_zero_duration();
    logic exp;
    set_note(3, 1, 0);
    req = 4'b1000;
    step();
    if (gnt !== 4'b1000) begin errors++; $display("FAIL zdur_gnt got %b want 1000", gnt); end
    checks++;
    req = '0;
    for (int c = 0; c < 8; c++) begin
      exp = (c < 4) && (c % 2 == 1);
      if (snd !== exp || busy !== 1'b1) begin
        errors++; $display("FAIL zdur_sound c%0d got snd=%b busy=%b want %b 1", c, snd, busy, exp);
      end
      checks++;
      step();
    end
    if (done !== 4'b1000) begin errors++; $display("FAIL zdur_done got %b want 1000", done); end
    checks++;
  endtask
  task automatic test_reset_mid_play();
    do_reset();
    set_note(2, 2, 3);
    req = 4'b0100;
    step();
    if (gnt !== 4'b0100) begin errors++; $display("FAIL rmid_gnt got %b want 0100", gnt); end
    checks++;
    req = '0;
    step();
    step();
    if (snd !== 1'b1) begin errors++; $display("FAIL rmid_sound_pre got %b want 1", snd); end
    checks++;
    rst = 1'b1;
    step();
    rst = 1'b0;
    if (snd !== 1'b0 || busy !== 1'b0 || aid !== 2'd0) begin
      errors++; $display("FAIL rmid_after got snd=%b busy=%b aid=%0d want 0 0 0", snd, busy, aid);
    end
    checks++;
    for (int c = 0; c < 15; c++) begin
      if (done !== 4'b0) begin errors++; $display("FAIL rmid_no_done c%0d got %b want 0000", c, done); end
      checks++;
      step();
    end
    set_note(1, 1, 1);
    set_note(3, 1, 1);
    req = 4'b1010;
    step();
    if (gnt !== 4'b0010) begin errors++; $display("FAIL rmid_rr_gnt got %b want 0010", gnt); end
    checks++;
    req = '0;
    repeat (9) step();
  endtask
  task automatic test_preempt();
    do_reset();
    set_note(2, 2, 5);
    set_note(0, 1, 1);
    req = 4'b0100;
    step();
    if (gnt !== 4'b0100) begin errors++; $display("FAIL pre_gnt2 got %b want 0100", gnt); end
    checks++;
    req = '0;
    repeat (8) step();
    req = 4'b0001;
`ifdef TONE_ARB_PREEMPT_EN
    step();
    if (busy !== 1'b0 || snd !== 1'b0 || done !== 4'b0) begin
      errors++; $display("FAIL pre_abort got busy=%b snd=%b done=%b want 0 0 0000", busy, snd, done);
    end
    checks++;
    step();
    if (gnt !== 4'b0001) begin errors++; $display("FAIL pre_gnt0 got %b want 0001", gnt); end
    checks++;
    req = '0;
    for (int c = 0; c < 10; c++) begin
      if (done[2] !== 1'b0) begin errors++; $display("FAIL pre_no_done2 c%0d got %b want 0", c, done[2]); end
      checks++;
      step();
    end
`else
    for (int c = 8; c < 24; c++) begin
      if (gnt !== 4'b0 || busy !== 1'b1) begin
        errors++; $display("FAIL nopre_hold c%0d got gnt=%b busy=%b want 0000 1", c, gnt, busy);
      end
      checks++;
      step();
    end
    if (done !== 4'b0100) begin errors++; $display("FAIL nopre_done2 got %b want 0100", done); end
    checks++;
    step();
    if (gnt !== 4'b0001 || aid !== 2'd0) begin
      errors++; $display("FAIL nopre_gnt0 got gnt=%b aid=%0d want 0001 0", gnt, aid);
    end
    checks++;
    req = '0;
    repeat (9) step();
`endif
  endtask
  initial begin
    test_reset();
    test_basic_note();
    test_round_robin();
    test_rest();
    test_zero_duration();
    test_reset_mid_play();
    test_preempt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
